iq_offset_cal: RTL
==================

IQ_OFFSET_CAL -- requirements
Module: iq_offset_cal

Interface
REQ-001 SHALL have parameter CAL_LOG2, default 6, log2 of the calibration sample count (64 samples).
REQ-002 SHALL have port symbol_clock, in, 1: clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, in, 1: reset, synchronous, active-high.
REQ-004 SHALL have port iq_valid_in, in, 1: I_raw/Q_raw hold a valid sample this cycle.
REQ-005 SHALL have port I_raw, in, 8: signed raw in-phase sample from the ADC front end.
REQ-006 SHALL have port Q_raw, in, 8: signed raw quadrature sample.
REQ-007 SHALL have port cal_start, in, 1: request an offset calibration; only a level is sampled.
REQ-008 SHALL have port I_out, out, 8: signed offset-corrected I, feeding the demapper I_in.
REQ-009 SHALL have port Q_out, out, 8: signed offset-corrected Q, feeding the demapper Q_in.
REQ-010 SHALL have port iq_valid_out, out, 1: I_out/Q_out are valid.
REQ-011 SHALL have port cal_busy, out, 1: high while in ACCUM or LATCH.
REQ-012 SHALL have port cal_done, out, 1: one-cycle pulse that coincides with new offsets becoming visible.
REQ-013 SHALL have port offset_I, out, 8: signed current I offset register.
REQ-014 SHALL have port offset_Q, out, 8: signed current Q offset register.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and LATCH.
REQ-016 SHALL move IDLE->ACCUM on the edge where cal_start=1, and SHALL clear both accumulators and the sample counter on that edge.
REQ-017 SHALL, in ACCUM, add I_raw/Q_raw to signed accumulators of width 8+CAL_LOG2 and increment the counter only on cycles with iq_valid_in=1; cycles with iq_valid_in=0 are ignored.
REQ-018 SHALL move ACCUM->LATCH on the edge that accumulates valid sample number 2^CAL_LOG2 (counter = 2^CAL_LOG2-1 with valid); the counter SHALL never wrap inside ACCUM.
REQ-019 SHALL, in LATCH, load offset_I/offset_Q with the accumulator arithmetically shifted right by CAL_LOG2 (floor toward -inf), truncated to 8 bits, pulse cal_done=1 for one cycle and return to IDLE (LATCH->IDLE on that edge).
REQ-020 SHALL ignore cal_start while in ACCUM or LATCH, with no restart.
REQ-021 SHALL compute the correction as out = saturate(raw - offset), using a 9-bit signed intermediate clamped to [-128,127].
REQ-022 SHALL register the correction with latency 1: I_out/Q_out/iq_valid_out at edge n+1 reflect the inputs at edge n.
REQ-023 SHALL hold I_out/Q_out when iq_valid_in=0 and drive iq_valid_out=0 on the next cycle.
REQ-024 SHALL keep correcting with the old offsets during ACCUM/LATCH; new offsets apply to samples presented in the cycle cal_done=1 and after.

Reset
REQ-025 SHALL, on rst=1 (synchronous, in any state including mid-ACCUM), force state=IDLE, clear accumulators and counter, and set I_out=0, Q_out=0, iq_valid_out=0, cal_busy=0, cal_done=0, offset_I=0 and offset_Q=0.
REQ-026 SHALL give rst priority over cal_start and iq_valid_in on the same edge.

Structure
REQ-027 SHALL define the FSM state encoding, sample width 8, and saturation limits +127/-128 in a shared package qam_pkg.
REQ-028 SHALL implement subtract-and-saturate as one combinational sub-module iq_sat_sub, instantiated twice (I, Q).

Verification
REQ-029 SHALL cover: after reset, valid I_raw=50, Q_raw=-20 -> next cycle I_out=50, Q_out=-20, iq_valid_out=1.
REQ-030 SHALL cover: cal_start, then 64 valid samples I=10, Q=-6 -> cal_done pulse two edges after the 64th sample, offset_I=10, offset_Q=-6; then I_raw=10 -> I_out=0.
REQ-031 SHALL cover floor and saturation: calibrate on 32 samples of 0 and 32 samples of -1 -> offset=-1; calibrate I=-100, then I_raw=100 -> I_out=127; calibrate I=100, then I_raw=-100 -> I_out=-128.
REQ-032 SHALL cover: iq_valid_in toggling every cycle during ACCUM -> cal_done only after 64 valid samples (~128 cycles); cal_start pulsed mid-ACCUM -> no restart and same offsets.
REQ-033 SHALL cover: rst asserted after 20 ACCUM samples -> cal_busy=0, offsets=0; a new calibration then requires a full 64 samples.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared sample width, saturation limits and calibration FSM encoding for the
// QAM receive front end.
package qam_pkg;

  localparam int SAMPLE_W = 8;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 8'sh7F;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 8'sh80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_LATCH = 2'd2
  } cal_state_t;

endpackage

// File: rtl/iq_sat_sub.sv
// Combinational raw - offset with a one-bit-wider intermediate, clamped to the
// signed sample range.
module iq_sat_sub
  import qam_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] raw,
  input  logic signed [SAMPLE_W-1:0] offset,
  output logic signed [SAMPLE_W-1:0] result
);

  logic signed [SAMPLE_W:0] diff;

  always_comb begin
    diff = $signed({raw[SAMPLE_W-1], raw}) - $signed({offset[SAMPLE_W-1], offset});
    if (diff > $signed({SAT_MAX[SAMPLE_W-1], SAT_MAX})) begin
      result = SAT_MAX;
    end else if (diff < $signed({SAT_MIN[SAMPLE_W-1], SAT_MIN})) begin
      result = SAT_MIN;
    end else begin
      result = diff[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/iq_offset_cal.sv
// DC offset calibration: averages 2^CAL_LOG2 valid I/Q samples on request and
// subtracts the stored offsets from the stream with one cycle of latency.
module iq_offset_cal
  import qam_pkg::*;
#(
  parameter int CAL_LOG2 = 6
) (
  input  logic                       symbol_clock,
  input  logic                       rst,
  input  logic                       iq_valid_in,
  input  logic signed [SAMPLE_W-1:0] I_raw,
  input  logic signed [SAMPLE_W-1:0] Q_raw,
  input  logic                       cal_start,
  output logic signed [SAMPLE_W-1:0] I_out,
  output logic signed [SAMPLE_W-1:0] Q_out,
  output logic                       iq_valid_out,
  output logic                       cal_busy,
  output logic                       cal_done,
  output logic signed [SAMPLE_W-1:0] offset_I,
  output logic signed [SAMPLE_W-1:0] offset_Q
);

  localparam int ACC_W = SAMPLE_W + CAL_LOG2;

  cal_state_t state, state_next;
  logic acc_clear, acc_en, do_latch;
  logic [CAL_LOG2-1:0] sample_cnt;
  logic cnt_last;
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [SAMPLE_W-1:0] corr_i, corr_q;

  assign cnt_last = (sample_cnt == {CAL_LOG2{1'b1}});
  assign cal_busy = (state == ST_ACCUM) || (state == ST_LATCH);

  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_clear  = 1'b0;
    acc_en     = 1'b0;
    do_latch   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cal_start) begin
          state_next = ST_ACCUM;
          acc_clear  = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (iq_valid_in) begin
          acc_en = 1'b1;
          if (cnt_last) begin
            state_next = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        do_latch   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      acc_i        <= '0;
      acc_q        <= '0;
      sample_cnt   <= '0;
      offset_I     <= '0;
      offset_Q     <= '0;
      cal_done     <= 1'b0;
      I_out        <= '0;
      Q_out        <= '0;
      iq_valid_out <= 1'b0;
    end else begin
      if (acc_clear) begin
        acc_i      <= '0;
        acc_q      <= '0;
        sample_cnt <= '0;
      end else if (acc_en) begin
        acc_i <= acc_i + {{CAL_LOG2{I_raw[SAMPLE_W-1]}}, I_raw};
        acc_q <= acc_q + {{CAL_LOG2{Q_raw[SAMPLE_W-1]}}, Q_raw};
        if (!cnt_last) begin
          sample_cnt <= sample_cnt + 1'b1;
        end
      end

      // Top SAMPLE_W bits of the sum are the floor mean (arithmetic shift by CAL_LOG2).
      cal_done <= do_latch;
      if (do_latch) begin
        offset_I <= acc_i[CAL_LOG2 +: SAMPLE_W];
        offset_Q <= acc_q[CAL_LOG2 +: SAMPLE_W];
      end

      iq_valid_out <= iq_valid_in;
      if (iq_valid_in) begin
        I_out <= corr_i;
        Q_out <= corr_q;
      end
    end
  end

  iq_sat_sub u_sat_i (
    .raw    (I_raw),
    .offset (offset_I),
    .result (corr_i)
  );

  iq_sat_sub u_sat_q (
    .raw    (Q_raw),
    .offset (offset_Q),
    .result (corr_q)
  );

endmodule
